ped_request_ctrl: RTL and testbench

//  Upstream stage of the NS/EW light sequencer. Per crossing, synchronises and debounces a raw push-button,

---
 rtl/traffic_pkg.sv | 18 +
 rtl/ped_req_channel.sv | 88 ++++++++
 rtl/ped_request_ctrl.sv | 76 +++++++
 tb/tb_ped_request_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: types shared between the pedestrian request front end and the light sequencer.
//   req_state_e : per-crossing request FSM encoding (2'b11 is unused and recovers to idle)
//   light_e     : one-hot lamp colour codes driven by the sequencer
package traffic_pkg;

  typedef enum logic [1:0] {
    ReqIdle    = 2'b00,
    ReqPending = 2'b01,
    ReqGranted = 2'b10
  } req_state_e;

  typedef enum logic [2:0] {
    LightGreen  = 3'b001,
    LightYellow = 3'b010,
    LightRed    = 3'b100
  } light_e;

endpackage

// File: rtl/ped_req_channel.sv
// ped_req_channel: one pedestrian crossing. Synchronises and debounces the raw button, then
// latches a sticky request until the sequencer acknowledges it.
//   clk         in  system clock, rising edge
//   rst         in  asynchronous active-high reset
//   btn_raw     in  raw button level, asynchronous, 1 = pressed
//   req_ack     in  1-cycle pulse: request served
//   req_pending out registered, request latched and awaiting service
//   req_new     out registered 1-cycle pulse when a request is latched
module ped_req_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic req_ack,
  output logic req_pending,
  output logic req_new
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_rise;
  req_state_e      state_q, state_d;
  logic            pending_q, new_q;

  // Debounce: the level must differ from deb for DEBOUNCE_CYC consecutive cycles to be taken.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntLast) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Taken from the next-state so req_new lands on the same edge that sets deb.
  assign deb_rise = deb_d & ~deb_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ReqIdle: begin
        if (deb_rise) state_d = ReqPending;
      end
      ReqPending: begin
        // A button still held at service time must be released before it can request again.
        if (req_ack) state_d = deb_q ? ReqGranted : ReqIdle;
      end
      ReqGranted: begin
        if (!deb_q) state_d = ReqIdle;
      end
      default: state_d = ReqIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ReqIdle;
      pending_q <= 1'b0;
      new_q     <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pending_q <= (state_d == ReqPending);
      new_q     <= (state_q == ReqIdle) && deb_rise;
    end
  end

  assign req_pending = pending_q;
  assign req_new     = new_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: pedestrian request front end for the NS/EW light sequencer.
// One ped_req_channel per crossing (bit 0 = NS, bit 1 = EW) plus the WAIT lamp drive.
//   clk         in  system clock, rising edge
//   rst         in  asynchronous active-high reset
//   btn_raw     in  [NREQ] raw button levels, asynchronous, 1 = pressed
//   req_ack     in  [NREQ] 1-cycle pulse per channel: request served
//   req_pending out [NREQ] registered, request latched awaiting service
//   req_new     out [NREQ] registered 1-cycle pulse on a newly latched request
//   wait_lamp   out [NREQ] WAIT lamp drive
// Build option PED_BLINK_EN: WAIT lamps blink with a half-period of BLINK_CYC cycles using one
// shared counter; otherwise they are lit solidly while a request is pending.
module ped_request_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned BLINK_CYC    = 25000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] btn_raw,
  input  logic [NREQ-1:0] req_ack,
  output logic [NREQ-1:0] req_pending,
  output logic [NREQ-1:0] req_new,
  output logic [NREQ-1:0] wait_lamp
);

  for (genvar i = 0; i < NREQ; i++) begin : g_chan
    ped_req_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .req_ack    (req_ack[i]),
      .req_pending(req_pending[i]),
      .req_new    (req_new[i])
    );
  end

`ifdef PED_BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_CYC + 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYC - 1);

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Phase starts lit so a fresh request shows immediately after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign wait_lamp = req_pending & {NREQ{phase_q}};
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_CYC;

  assign wait_lamp = req_pending;
`endif

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Bench for ped_request_ctrl: directed scenarios followed by randomized button/ack/reset
// traffic. A reference model predicts every output vector; a monitor compares them.
module tb_ped_request_ctrl;

  localparam int NReq  = 2;
  localparam int Deb   = 4;
  localparam int Blink = 3;

  logic            clk;
  logic            rst;
  logic [NReq-1:0] btn_raw;
  logic [NReq-1:0] req_ack;
  logic [NReq-1:0] req_pending;
  logic [NReq-1:0] req_new;
  logic [NReq-1:0] wait_lamp;

  ped_request_ctrl #(
    .NREQ        (NReq),
    .DEBOUNCE_CYC(Deb),
    .BLINK_CYC   (Blink)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .req_ack    (req_ack),
    .req_pending(req_pending),
    .req_new    (req_new),
    .wait_lamp  (wait_lamp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Expected {req_pending, req_new, wait_lamp} after each rising edge.
  logic [3*NReq-1:0] exp_q[$];

  // Reference model state. n counts edges since reset released; raw_log[c][k] is the button
  // level sampled at edge k+1. The channel sees the button two edges late.
  int n;
  bit raw_log[NReq][$];
  int last_flip[NReq];
  bit m_deb[NReq];
  bit m_pend[NReq];
  bit m_block[NReq];

  function automatic bit sync_at(input int c, input int k);
    if (k >= 3) return raw_log[c][k-3];
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [NReq-1:0] p, nw, l;
    bit              phase;
    if (rst) begin
      n = 0;
      for (int c = 0; c < NReq; c++) begin
        raw_log[c].delete();
        last_flip[c] = 0;
        m_deb[c]     = 1'b0;
        m_pend[c]    = 1'b0;
        m_block[c]   = 1'b0;
      end
      exp_q.push_back('0);
      return;
    end
    n++;
    // Lamp phase flips every Blink edges, starting lit.
    phase = (((n / Blink) % 2) == 0);
    for (int c = 0; c < NReq; c++) begin
      bit old_deb, flip;
      raw_log[c].push_back(btn_raw[c]);
      old_deb = m_deb[c];
      // Level accepted once it has disagreed with deb on Deb consecutive edges since the last change.
      flip = ((n - last_flip[c]) >= Deb);
      if (flip) begin
        for (int j = 0; j < Deb; j++) begin
          if (sync_at(c, n - j) == old_deb) flip = 1'b0;
        end
      end
      if (flip) begin
        m_deb[c]     = !old_deb;
        last_flip[c] = n;
      end
      nw[c] = 1'b0;
      if (m_pend[c]) begin
        if (req_ack[c]) begin
          m_pend[c]  = 1'b0;
          m_block[c] = old_deb;
        end
      end else if (m_block[c]) begin
        if (!old_deb) m_block[c] = 1'b0;
      end else if (flip && m_deb[c]) begin
        m_pend[c] = 1'b1;
        nw[c]     = 1'b1;
      end
      p[c] = m_pend[c];
    end
`ifdef PED_BLINK_EN
    l = p & {NReq{phase}};
`else
    l = p;
`endif
    exp_q.push_back({p, nw, l});
  endtask

  task automatic cycle(input logic [NReq-1:0] b, input logic [NReq-1:0] a, input logic r);
    @(negedge clk);
    btn_raw = b;
    req_ack = a;
    rst     = r;
    @(posedge clk);
    model_step();
  endtask

  // Monitor: one comparison per predicted output vector, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        logic [3*NReq-1:0] e, a;
        e = exp_q.pop_front();
        a = {req_pending, req_new, wait_lamp};
        tests++;
        if (a !== e) begin
          fails++;
          if (fails <= 30)
            $display("FAIL outputs{pend,new,lamp} at cycle %0d: got %b required %b", cyc, a, e);
        end
      end
    end
  end

  initial begin
    logic [NReq-1:0] b;
    int              hold[NReq];
    rst     = 1'b1;
    btn_raw = '0;
    req_ack = '0;

    // Both buttons held through reset: both request Deb+2 edges after release.
    repeat (3) cycle(2'b11, 2'b00, 1'b1);
    repeat (10) cycle(2'b11, 2'b00, 1'b0);
    // Ack ch0 while held, then re-press attempts while held do nothing.
    cycle(2'b11, 2'b01, 1'b0);
    repeat (6) cycle(2'b11, 2'b00, 1'b0);
    repeat (8) cycle(2'b10, 2'b00, 1'b0);
    // 3-cycle glitch ignored, 4-cycle press accepted.
    repeat (3) cycle(2'b11, 2'b00, 1'b0);
    repeat (8) cycle(2'b10, 2'b00, 1'b0);
    repeat (4) cycle(2'b11, 2'b00, 1'b0);
    repeat (8) cycle(2'b10, 2'b00, 1'b0);
    // Ch1 pending: release, re-press, release, then ack with deb low.
    repeat (8) cycle(2'b00, 2'b00, 1'b0);
    repeat (8) cycle(2'b10, 2'b00, 1'b0);
    repeat (8) cycle(2'b00, 2'b00, 1'b0);
    cycle(2'b00, 2'b10, 1'b0);
    repeat (2) cycle(2'b00, 2'b00, 1'b0);
    // Ack on both bits with only ch0 pending; then a stray ack in idle.
    cycle(2'b00, 2'b11, 1'b0);
    repeat (3) cycle(2'b00, 2'b00, 1'b0);
    cycle(2'b00, 2'b11, 1'b0);
    // Ch0 pending long enough to see the lamp pattern, plus a press right after an ack.
    repeat (5) cycle(2'b01, 2'b00, 1'b0);
    repeat (4) cycle(2'b00, 2'b00, 1'b0);
    repeat (12) cycle(2'b00, 2'b00, 1'b0);
    cycle(2'b00, 2'b01, 1'b0);
    repeat (5) cycle(2'b01, 2'b00, 1'b0);
    repeat (12) cycle(2'b00, 2'b00, 1'b0);

    // Randomized traffic: mixed glitches and real presses, random acks, rare resets.
    b = '0;
    for (int c = 0; c < NReq; c++) hold[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      logic [NReq-1:0] a;
      logic            r;
      for (int c = 0; c < NReq; c++) begin
        if (hold[c] == 0) begin
          b[c]    = ~b[c];
          hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 14));
        end
        hold[c]--;
        a[c] = m_pend[c] ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      end
      r = ($urandom_range(0, 399) == 0);
      cycle(b, a, r);
    end

    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
